// File: rtl/io_event_pkg.sv
// Shared definitions for the user-IO event path: event source indices,
// the default event word width and a sizing helper.
package io_event_pkg;

  localparam int EV_SRC_BUTTONS = 0;
  localparam int EV_SRC_UART    = 1;
  localparam int EV_SRC_TIMER   = 2;
  localparam int EV_SRC_MIC     = 3;

  localparam int EV_DATA_WIDTH  = 8;

  // Index width for n items, never below one bit so selects stay legal for n <= 2.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority picker: the search starts just after
// rr_ptr and wraps, so the last winner gets the lowest priority next time.
module rr_arbiter
  import io_event_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/event_fifo_arbiter.sv
// Shares the user-IO event FIFO between several event sources, each with a
// one-entry holding buffer drained round-robin into the FIFO write port.
module event_fifo_arbiter
  import io_event_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = EV_DATA_WIDTH,
  parameter int DROP_MODE  = 0,
  parameter int CNT_WIDTH  = 16,
  parameter int IDX_W      = clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [IDX_W-1:0]              grant_id,
  output logic [CNT_WIDTH-1:0]          drop_count,
  output logic                          busy
);

  localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NUM_REQ - 1);
  localparam int POP_W = clog2(NUM_REQ + 1);
  localparam int SUM_W = ((CNT_WIDTH > POP_W) ? CNT_WIDTH : POP_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W - CNT_WIDTH){1'b0}}, {CNT_WIDTH{1'b1}}};

  logic [NUM_REQ-1:0]    occ;
  logic [DATA_WIDTH-1:0] ev_buf [NUM_REQ];
  logic [IDX_W-1:0]      rr_ptr;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   winner;
  logic               any_occ;
  logic               grant;
  logic [NUM_REQ-1:0] drained;
  logic [NUM_REQ-1:0] free_slot;
  logic [NUM_REQ-1:0] accept;
  logic [NUM_REQ-1:0] dropped;
  logic [POP_W-1:0]   drop_pop;
  logic [SUM_W-1:0]   drop_sum;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req    (occ),
    .rr_ptr (rr_ptr),
    .grant  (pick_oh),
    .idx    (winner),
    .any    (any_occ)
  );

  assign grant   = any_occ & ~fifo_full;
  assign drained = grant ? pick_oh : '0;

  // A buffer being drained this cycle can take a new event in the same cycle.
  assign free_slot = ~occ | drained;

  assign req_ready = !rst ? '0 : ((DROP_MODE != 0) ? '1 : free_slot);
  assign accept    = req_valid & free_slot;
  assign dropped   = (DROP_MODE != 0) ? (req_valid & ~free_slot) : '0;

  always_comb begin
    drop_pop = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      drop_pop = drop_pop + POP_W'(dropped[i]);
    end
  end

  assign drop_sum = SUM_W'(drop_count) + SUM_W'(drop_pop);

  assign fifo_wr_en = grant;
  assign fifo_din   = grant ? ev_buf[winner] : '0;
  assign grant_id   = grant ? winner : '0;
  assign busy       = |occ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ        <= '0;
      rr_ptr     <= PTR_INIT;
      drop_count <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        ev_buf[i] <= '0;
      end
    end else begin
      if (grant) begin
        rr_ptr <= winner;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          ev_buf[i] <= req_data[i*DATA_WIDTH +: DATA_WIDTH];
          occ[i]    <= 1'b1;
        end else if (drained[i]) begin
          occ[i] <= 1'b0;
        end
      end
      // Several requesters can drop in one cycle; clamp instead of wrapping.
      if (drop_sum > CNT_MAX) begin
        drop_count <= {CNT_WIDTH{1'b1}};
      end else begin
        drop_count <= drop_sum[CNT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_event_fifo_arbiter.sv
// Bench for event_fifo_arbiter: a back-pressure instance checked against a
// queue-level model and a drop-mode instance checked with directed values.
module tb_event_fifo_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          fifo_full;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_din;
  logic [1:0]    grant_id;
  logic [15:0]   drop_count;
  logic          busy;

  logic          rst_d;
  logic [N-1:0]  req_valid_d;
  logic [N*DW-1:0] req_data_d;
  logic [N-1:0]  req_ready_d;
  logic          fifo_full_d;
  logic          fifo_wr_en_d;
  logic [DW-1:0] fifo_din_d;
  logic [1:0]    grant_id_d;
  logic [15:0]   drop_count_d;
  logic          busy_d;

  int n_compared   = 0;
  int n_mismatched = 0;

  event_fifo_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .DROP_MODE(0), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .drop_count (drop_count),
    .busy       (busy)
  );

  event_fifo_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .DROP_MODE(1), .CNT_WIDTH(16)) dut_drop (
    .clk        (clk),
    .rst        (rst_d),
    .req_valid  (req_valid_d),
    .req_data   (req_data_d),
    .req_ready  (req_ready_d),
    .fifo_full  (fifo_full_d),
    .fifo_wr_en (fifo_wr_en_d),
    .fifo_din   (fifo_din_d),
    .grant_id   (grant_id_d),
    .drop_count (drop_count_d),
    .busy       (busy_d)
  );

  // Reference model: one pending slot per source plus the last served source.
  bit            m_occ [N];
  logic [DW-1:0] m_buf [N];
  int            m_last;

  bit            exp_wr;
  logic [DW-1:0] exp_din;
  logic [1:0]    exp_id;
  logic [N-1:0]  exp_ready;
  bit            exp_busy;
  int            exp_win;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_occ[i] = 0;
      m_buf[i] = '0;
    end
    m_last = N - 1;
  endtask

  task automatic model_expect();
    exp_win = -1;
    for (int k = 1; k <= N; k++) begin
      int c = (m_last + k) % N;
      if (exp_win < 0 && m_occ[c]) exp_win = c;
    end
    exp_wr   = (exp_win >= 0) && !fifo_full;
    exp_din  = exp_wr ? m_buf[exp_win] : '0;
    exp_id   = exp_wr ? 2'(exp_win) : 2'd0;
    exp_busy = 0;
    for (int i = 0; i < N; i++) begin
      exp_busy     = exp_busy | m_occ[i];
      exp_ready[i] = !m_occ[i] || (exp_wr && exp_win == i);
    end
  endtask

  task automatic model_advance();
    if (exp_wr) begin
      m_occ[exp_win] = 0;
      m_last = exp_win;
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && exp_ready[i]) begin
        m_occ[i] = 1;
        m_buf[i] = req_data[i*DW +: DW];
      end
    end
  endtask

  task automatic settle0();
    @(negedge clk);
    model_expect();
  endtask

  task automatic commit0();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset0();
    rst = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic do_reset1();
    rst_d = 1'b0;
    req_valid_d = '0;
    req_data_d  = '0;
    fifo_full_d = 1'b0;
    @(posedge clk);
    #1;
    rst_d = 1'b1;
  endtask

  task automatic test_reset();
    do_reset0();
    req_valid = 4'b1111;
    req_data  = 32'h44332211;
    settle0();
    commit0();
    settle0();
    n_compared++;
    if ({fifo_wr_en, fifo_din, busy} !== {1'b1, 8'h11, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL pre_reset_state: got wr=%0b din=%h busy=%0b need wr=1 din=11 busy=1", fifo_wr_en, fifo_din, busy);
    end
    #1 rst = 1'b0;
    #1;
    n_compared++;
    if ({fifo_wr_en, busy, drop_count, req_ready, fifo_din, grant_id} !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_outputs: got wr=%0b busy=%0b drops=%h ready=%b din=%h id=%0d need all zero",
               fifo_wr_en, busy, drop_count, req_ready, fifo_din, grant_id);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = 4'b0001;
    req_data  = 32'h0000005A;
    settle0();
    n_compared++;
    if ({fifo_wr_en, req_ready[0]} !== 2'b01) begin
      n_mismatched++;
      $display("[TB] FAIL reset_first_accept: got wr=%0b ready0=%0b need wr=0 ready0=1", fifo_wr_en, req_ready[0]);
    end
    commit0();
    req_valid = '0;
    settle0();
    n_compared++;
    if ({fifo_wr_en, fifo_din, grant_id} !== {1'b1, 8'h5A, 2'd0}) begin
      n_mismatched++;
      $display("[TB] FAIL reset_first_write: got wr=%0b din=%h id=%0d need wr=1 din=5a id=0", fifo_wr_en, fifo_din, grant_id);
    end
    commit0();
  endtask

  task automatic test_all_pending();
    logic [DW-1:0] order [4];
    order = '{8'h10, 8'h21, 8'h32, 8'h43};
    do_reset0();
    req_valid = 4'b1111;
    req_data  = 32'h43322110;
    settle0();
    commit0();
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      settle0();
      n_compared++;
      if ({fifo_wr_en, fifo_din, grant_id} !== {1'b1, order[k], 2'(k)}) begin
        n_mismatched++;
        $display("[TB] FAIL all_pending_%0d: got wr=%0b din=%h id=%0d need wr=1 din=%h id=%0d",
                 k, fifo_wr_en, fifo_din, grant_id, order[k], k);
      end
      commit0();
    end
    settle0();
    n_compared++;
    if ({fifo_wr_en, busy} !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL all_pending_idle: got wr=%0b busy=%0b need 0 0", fifo_wr_en, busy);
    end
    commit0();
  endtask

  task automatic test_round_robin();
    int gh [32];
    do_reset0();
    for (int c = 0; c < 9; c++) begin
      req_valid = 4'b1010;
      req_data  = {8'(c), 8'h00, 8'(c), 8'h00};
      settle0();
      if (c >= 1) begin
        n_compared++;
        if ({fifo_wr_en, grant_id} !== {1'b1, ((c % 2 == 1) ? 2'd1 : 2'd3)}) begin
          n_mismatched++;
          $display("[TB] FAIL rr_alternate_c%0d: got wr=%0b id=%0d need wr=1 id=%0d",
                   c, fifo_wr_en, grant_id, (c % 2 == 1) ? 1 : 3);
        end
      end
      commit0();
    end
    for (int c = 9; c < 24; c++) begin
      req_valid = 4'b1011;
      req_data  = {8'(c), 8'h00, 8'(c), 8'(c)};
      settle0();
      gh[c] = fifo_wr_en ? int'(grant_id) : -1;
      n_compared++;
      if ({fifo_wr_en, fifo_din, grant_id, req_ready, busy} !== {exp_wr, exp_din, exp_id, exp_ready, exp_busy}) begin
        n_mismatched++;
        $display("[TB] FAIL rr_join_c%0d: got wr=%0b din=%h id=%0d ready=%b need wr=%0b din=%h id=%0d ready=%b",
                 c, fifo_wr_en, fifo_din, grant_id, req_ready, exp_wr, exp_din, exp_id, exp_ready);
      end
      if (c >= 12) begin
        n_compared++;
        if (gh[c] < 0 || gh[c] == gh[c-1] || gh[c] == gh[c-2]) begin
          n_mismatched++;
          $display("[TB] FAIL rr_fairness_c%0d: got grants %0d,%0d,%0d need three distinct",
                   c, gh[c-2], gh[c-1], gh[c]);
        end
      end
      commit0();
    end
  endtask

  task automatic test_back_pressure();
    do_reset0();
    fifo_full = 1'b1;
    req_valid = 4'b0100;
    req_data  = 32'h007E0000;
    settle0();
    commit0();
    req_data = 32'h00110000;
    for (int c = 0; c < 5; c++) begin
      settle0();
      n_compared++;
      if ({fifo_wr_en, req_ready[2], busy} !== 3'b001) begin
        n_mismatched++;
        $display("[TB] FAIL bp_stall_%0d: got wr=%0b ready2=%0b busy=%0b need 0 0 1", c, fifo_wr_en, req_ready[2], busy);
      end
      commit0();
    end
    fifo_full = 1'b0;
    req_valid = '0;
    settle0();
    n_compared++;
    if ({fifo_wr_en, fifo_din, grant_id, req_ready[2]} !== {1'b1, 8'h7E, 2'd2, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL bp_release: got wr=%0b din=%h id=%0d ready2=%0b need wr=1 din=7e id=2 ready2=1",
               fifo_wr_en, fifo_din, grant_id, req_ready[2]);
    end
    commit0();
    settle0();
    n_compared++;
    if ({fifo_wr_en, busy} !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL bp_after: got wr=%0b busy=%0b need 0 0", fifo_wr_en, busy);
    end
    commit0();
  endtask

  task automatic test_drain_refill();
    do_reset0();
    for (int c = 0; c <= 8; c++) begin
      req_valid = (c < 8) ? 4'b0001 : 4'b0000;
      req_data  = {24'h0, 8'(c + 1)};
      settle0();
      if (c < 8) begin
        n_compared++;
        if (req_ready[0] !== 1'b1) begin
          n_mismatched++;
          $display("[TB] FAIL refill_ready_%0d: got %0b need 1", c, req_ready[0]);
        end
      end
      if (c >= 1) begin
        n_compared++;
        if ({fifo_wr_en, fifo_din} !== {1'b1, 8'(c)}) begin
          n_mismatched++;
          $display("[TB] FAIL refill_write_%0d: got wr=%0b din=%h need wr=1 din=%h", c, fifo_wr_en, fifo_din, 8'(c));
        end
      end
      commit0();
    end
  endtask

  task automatic test_random();
    do_reset0();
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom);
      req_data  = $urandom;
      fifo_full = ($urandom_range(0, 3) == 0);
      settle0();
      n_compared++;
      if ({fifo_wr_en, fifo_din, grant_id, req_ready, busy} !== {exp_wr, exp_din, exp_id, exp_ready, exp_busy}) begin
        n_mismatched++;
        $display("[TB] FAIL random_c%0d: got wr=%0b din=%h id=%0d ready=%b busy=%0b need wr=%0b din=%h id=%0d ready=%b busy=%0b",
                 c, fifo_wr_en, fifo_din, grant_id, req_ready, busy, exp_wr, exp_din, exp_id, exp_ready, exp_busy);
      end
      commit0();
    end
    fifo_full = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_drop_mode();
    logic [DW-1:0] seq [3];
    seq = '{8'hAA, 8'hBB, 8'hCC};
    do_reset1();
    fifo_full_d = 1'b1;
    req_valid_d = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      req_data_d = {24'h0, seq[k]};
      @(negedge clk);
      n_compared++;
      if ({req_ready_d, fifo_wr_en_d} !== 5'b11110) begin
        n_mismatched++;
        $display("[TB] FAIL drop_ready_%0d: got ready=%b wr=%0b need ready=1111 wr=0", k, req_ready_d, fifo_wr_en_d);
      end
      @(posedge clk);
      #1;
    end
    req_valid_d = '0;
    fifo_full_d = 1'b0;
    @(negedge clk);
    n_compared++;
    if ({fifo_wr_en_d, fifo_din_d, grant_id_d, drop_count_d} !== {1'b1, 8'hAA, 2'd0, 16'd2}) begin
      n_mismatched++;
      $display("[TB] FAIL drop_keep_oldest: got wr=%0b din=%h id=%0d drops=%0d need wr=1 din=aa id=0 drops=2",
               fifo_wr_en_d, fifo_din_d, grant_id_d, drop_count_d);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_compared++;
    if ({fifo_wr_en_d, busy_d, drop_count_d} !== {1'b0, 1'b0, 16'd2}) begin
      n_mismatched++;
      $display("[TB] FAIL drop_after: got wr=%0b busy=%0b drops=%0d need wr=0 busy=0 drops=2",
               fifo_wr_en_d, busy_d, drop_count_d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_drop_saturation();
    do_reset1();
    fifo_full_d = 1'b1;
    req_valid_d = 4'b1111;
    req_data_d  = 32'hD3D2D1D0;
    @(posedge clk);
    #1;
    req_data_d = 32'hEEEEEEEE;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    n_compared++;
    if (drop_count_d !== 16'd40) begin
      n_mismatched++;
      $display("[TB] FAIL drop_popcount: got %0d need 40", drop_count_d);
    end
    for (int c = 0; c < 17500; c++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    n_compared++;
    if ({drop_count_d, fifo_wr_en_d, busy_d} !== {16'hFFFF, 1'b0, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL drop_saturate: got drops=%h wr=%0b busy=%0b need drops=ffff wr=0 busy=1",
               drop_count_d, fifo_wr_en_d, busy_d);
    end
    @(posedge clk);
    #1;
    req_valid_d = '0;
    fifo_full_d = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_compared++;
      if ({fifo_wr_en_d, fifo_din_d, grant_id_d, drop_count_d} !== {1'b1, 8'(8'hD0 + k), 2'(k), 16'hFFFF}) begin
        n_mismatched++;
        $display("[TB] FAIL drop_drain_%0d: got wr=%0b din=%h id=%0d drops=%h need wr=1 din=%h id=%0d drops=ffff",
                 k, fifo_wr_en_d, fifo_din_d, grant_id_d, drop_count_d, 8'(8'hD0 + k), k);
      end
      @(posedge clk);
      #1;
    end
    rst_d = 1'b0;
    #1;
    n_compared++;
    if ({drop_count_d, req_ready_d, busy_d} !== 21'h0) begin
      n_mismatched++;
      $display("[TB] FAIL drop_reset: got drops=%h ready=%b busy=%0b need all zero", drop_count_d, req_ready_d, busy_d);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, compared=%0d", n_compared);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    rst_d = 1'b0;
    req_valid_d = '0;
    req_data_d  = '0;
    fifo_full_d = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_all_pending();
    test_round_robin();
    test_back_pressure();
    test_drain_refill();
    test_random();
    test_drop_mode();
    test_drop_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/event_fifo_arbiter.md
Name: event_fifo_arbiter

Overview:
- Shares the single 8-bit user-IO event FIFO between several event sources: the button/rotary packer, the UART command decoder and future timer/mic-threshold events.
- Each source gets a one-entry holding buffer with a valid/ready handshake.
- A round-robin scheduler drains the occupied buffers into the FIFO write port, one entry per cycle, honouring fifo_full.
- Sits between the event producers and the fifo instance that feeds the Riscv151 io_fifo port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, event word width.
- DROP_MODE, 0, 0 = back-pressure requesters; 1 = never stall requesters, count dropped events instead.
- CNT_WIDTH, 16, width of the saturating drop counter.

Ports:
- clk  input  1  CPU clock (cpu_clk_g domain).
- rst  input  1  asynchronous reset, active-low (0 = reset asserted).
- req_valid  input  NUM_REQ  per-requester event valid.
- req_data  input  NUM_REQ*DATA_WIDTH  packed event data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  per-requester accept.
- fifo_full  input  1  full flag from the event FIFO.
- fifo_wr_en  output  1  FIFO write strobe.
- fifo_din  output  DATA_WIDTH  FIFO write data.
- grant_id  output  clog2(NUM_REQ)  index of the requester written this cycle; valid only when fifo_wr_en=1.
- drop_count  output  CNT_WIDTH  saturating count of dropped events (always 0 when DROP_MODE=0).
- busy  output  1  OR of all buffer occupancy bits.

Behaviour:
- Reset (rst=0, asynchronous):
  - all occ[i]=0 and all buf[i]=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - drop_count=0.
  - Resulting outputs: fifo_wr_en=0, fifo_din=0, grant_id=0, busy=0.
  - req_ready=0 while in reset.
  - Reset mid-operation discards all buffered events without writing them.
- State per requester: occ[i] (1 bit) and buf[i] (DATA_WIDTH bits).
- Scheduler:
  - Combinational search over occ[], starting at (rr_ptr+1) mod NUM_REQ and wrapping.
  - First occupied index = winner.
  - grant = any_occ & ~fifo_full.
- Write port (combinational from registers plus fifo_full):
  - fifo_wr_en = grant.
  - fifo_din = buf[winner] when grant, else 0.
  - grant_id = winner when grant, else 0.
  - One FIFO write at most per cycle.
  - fifo_full=1 means fifo_wr_en=0; no state changes except accepts into empty buffers.
- rr_ptr <= winner on any cycle with grant; otherwise it holds.
- Handshake, DROP_MODE=0:
  - req_ready[i] = ~occ[i] | (grant & winner==i), so a buffer being drained can refill in the same cycle.
  - Accept when req_valid[i] & req_ready[i]: buf[i] <= req_data slice, occ[i] <= 1.
  - If requester i is drained and not refilled in a cycle: occ[i] <= 0.
- Handshake, DROP_MODE=1:
  - req_ready = all ones.
  - If req_valid[i] arrives while occ[i]=1 and i is not being granted: the new event is discarded, buf keeps the older event, drop_count increments.
  - Multiple simultaneous drops in one cycle add their popcount to drop_count.
  - drop_count saturates at 2^CNT_WIDTH-1.
- Latency: event accepted in cycle t is written no earlier than cycle t+1.
- Worst-case wait with the FIFO never full: NUM_REQ cycles.
- Fairness: a continuously valid requester is granted at most once every NUM_REQ cycles while all others are also pending.
- Simultaneous accept on every requester in one cycle: all NUM_REQ entries are captured.
- busy = |occ.

Decomposition:
- Shared package io_event_pkg:
  - event source index constants EV_SRC_BUTTONS=0, EV_SRC_UART=1, EV_SRC_TIMER=2, EV_SRC_MIC=3.
  - DATA_WIDTH default.
  - clog2 function.
- One sub-module, rr_arbiter: combinational round-robin priority picker.
  - Inputs: request vector, rr_ptr.
  - Outputs: one-hot grant, binary index, any.
  - Parameterised by NUM_REQ so the CPU MMIO bus arbiter can reuse it.
- Holding buffers and drop counter stay in the top module.

Test Plan:
- Reset:
  - Stimulus: assert rst=0 with occ set and req_valid high.
  - Response: immediately fifo_wr_en=0, busy=0, drop_count=0, req_ready=0.
  - Stimulus: release rst.
  - Response: the first accepted event from requester 0 (0x5A) appears on fifo_din one cycle later with grant_id=0.
- All four pending, fifo_full=0:
  - Stimulus: one cycle of req_valid=4'b1111 with data 0x10, 0x21, 0x32, 0x43.
  - Response: writes on four consecutive cycles in order 0x10, 0x21, 0x32, 0x43 with grant_id 0, 1, 2, 3; then busy=0.
- Round-robin wrap and fairness:
  - Stimulus: requesters 1 and 3 valid continuously (data = cycle number).
  - Response: grant_id alternates 1, 3, 1, 3.
  - Stimulus: requester 0 joins.
  - Response: the order continues from rr_ptr with no requester granted twice before the others.
- Back-pressure:
  - Stimulus: fifo_full=1 for 5 cycles with requester 2 holding 0x7E.
  - Response: fifo_wr_en=0, req_ready[2]=0, no data loss.
  - Stimulus: fifo_full drops.
  - Response: 0x7E is written in the same cycle and req_ready[2]=1 in that cycle.
- Drain-and-refill:
  - Stimulus: requester 0 streams 0x01..0x08 with valid held, other requesters idle.
  - Response: 8 writes on 8 consecutive cycles, req_ready[0] stays 1 throughout.
- DROP_MODE=1:
  - Stimulus: fifo_full=1; requester 0 sends 0xAA then 0xBB, 0xCC; fifo_full released.
  - Response: only 0xAA is written, drop_count=2.
  - Stimulus: force 70000 drops with CNT_WIDTH=16.
  - Response: drop_count saturates at 0xFFFF.
